msm_test_sequencer: RTL
=======================

Name: msm_test_sequencer

Overview:
- Self-checking run controller for the MSM HLS core on the test bench/board harness.
- On a run pulse it issues the ap_ctrl_hs start handshake to the core, waits for ap_done under a watchdog, then sequences port 1 of the bucket result memory B_i_V together with an expected-result memory.
- Compares every bucket word and reports pass/fail, mismatch count, first failing address and core latency.

Parameters:
- NUM_BKT, 32, number of bucket words checked; addresses 0..NUM_BKT-1.
- AW, 5, bucket address width; must satisfy NUM_BKT <= 2^AW.
- DW, 32, bucket word width.
- TIMEOUT, 1048576, maximum cycles from ap_start acceptance to ap_done.
- CYC_W, 24, width of the core-latency counter.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- run  in  1  single-cycle start request; ignored while busy
- core_ap_start  out  1  start to MSM core
- core_ap_ready  in  1  core accepted start
- core_ap_done  in  1  core finished (single-cycle pulse)
- B_i_V_address1  out  AW  bucket read address
- B_i_V_ce1  out  1  bucket read enable
- B_i_V_we1  out  1  tied 0
- B_i_V_d1  out  DW  tied 0
- B_i_V_q1  in  DW  bucket read data, valid 1 cycle after ce
- exp_address  out  AW  expected-memory address, always equals B_i_V_address1
- exp_ce  out  1  equals B_i_V_ce1
- exp_q  in  DW  expected word, 1-cycle latency
- busy  out  1  high outside IDLE/DONE
- done  out  1  sticky; set on entering DONE, cleared by accepted run or reset
- pass  out  1  valid while done; 1 = no mismatch and no timeout
- timeout  out  1  watchdog fired in the last run
- mismatch_cnt  out  AW+1  mismatching words in the last run
- first_bad_addr  out  AW  address of first mismatch; 0 if none
- core_cycles  out  CYC_W  cycles from start acceptance to ap_done, saturating at all-ones
- debug  out  1  equals done & ~pass

Behaviour:
- Reset (synchronous, ap_rst=1 at posedge) forces state IDLE and all outputs 0, including the counters and flags. Reset mid-run abandons the run immediately and drops core_ap_start in the same edge.
- IDLE: run=1 clears done, pass, timeout, mismatch_cnt, first_bad_addr and core_cycles, then goes to START.
- START: core_ap_start=1. It holds until the cycle core_ap_ready=1; on that edge go to WAIT. If ready and done arrive in the same cycle, go straight to READ with core_cycles=0.
- WAIT: core_cycles and the watchdog increment each cycle.
  - core_ap_done=1 leads to READ.
  - If the watchdog reaches TIMEOUT first, set timeout=1 and go to DONE without reading; pass=0.
  - ap_done and watchdog expiry in the same cycle: done wins.
- READ: pipelined, one word per cycle. Cycle k drives address k with ce=1 for k=0..NUM_BKT-1. Cycle k+1 compares B_i_V_q1 against exp_q.
  - On the first mismatch, latch first_bad_addr=k.
  - Each mismatch increments mismatch_cnt, which saturates at NUM_BKT.
  - After the last address, one DRAIN cycle compares the final word; then go to DONE. The read phase takes NUM_BKT+1 cycles.
- DONE: done=1. pass = (mismatch_cnt==0) & ~timeout, settled when done rises. run=1 starts a new run exactly as from IDLE.
- run while busy: ignored, no queuing.
- ce is 0 outside READ; the address holds its last value.

Optional Feature:
- MSM_SEQ_STOP_ON_MISMATCH_EN defined: the first mismatch ends READ. The in-flight issued address is discarded, the state goes to DONE the cycle after the compare, and mismatch_cnt=1.
- Undefined: all NUM_BKT words are always compared.

Test Plan:
- Expected memory equals the core result and ready follows start by 1 cycle; done arrives 100 cycles later -> core_cycles=100, pass=1, mismatch_cnt=0, done rises 33 cycles after ap_done.
- Words 3 and 17 corrupted -> pass=0, mismatch_cnt=2, first_bad_addr=3, debug=1.
- Macro defined, words 3 and 17 corrupted -> mismatch_cnt=1, first_bad_addr=3, only addresses 0..4 issued.
- Core never asserts ap_done, TIMEOUT=64 -> timeout=1, pass=0, no ce pulses, done after 64 WAIT cycles.
- ap_rst asserted during READ at address 10 -> next cycle all outputs 0, core_ap_start=0, ce=0; a following run completes normally.
- run pulsed during WAIT and on the same cycle as ready+done -> the extra run is ignored; same-cycle ready+done gives core_cycles=0 and a correct compare.

Source files
------------

// File: rtl/msm_test_sequencer.sv
// Run controller for the MSM HLS core: start handshake, watchdog, bucket readback and compare.
// Optional build macro MSM_SEQ_STOP_ON_MISMATCH_EN ends the read phase at the first mismatch.
module msm_test_sequencer #(
    parameter int NUM_BKT = 32,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1048576,
    parameter int CYC_W   = 24
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             run,
    output logic             core_ap_start,
    input  logic             core_ap_ready,
    input  logic             core_ap_done,
    output logic [AW-1:0]    B_i_V_address1,
    output logic             B_i_V_ce1,
    output logic             B_i_V_we1,
    output logic [DW-1:0]    B_i_V_d1,
    input  logic [DW-1:0]    B_i_V_q1,
    output logic [AW-1:0]    exp_address,
    output logic             exp_ce,
    input  logic [DW-1:0]    exp_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [AW:0]      mismatch_cnt,
    output logic [AW-1:0]    first_bad_addr,
    output logic [CYC_W-1:0] core_cycles,
    output logic             debug
);
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int STAGES = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     rd_addr, cmp_addr;
    logic [STAGES:0]   vld_pipe;
    logic [WD_W-1:0]   wd_cnt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [AW:0]       mm_cnt;
    logic [AW-1:0]     bad_addr;
    logic              done_r, timeout_r;
    logic              start_acc, last_addr, wd_exp, cmp_en, word_bad, to_read;

    assign start_acc = run && (state == S_IDLE || state == S_DONE);
    assign last_addr = rd_addr == AW'(NUM_BKT - 1);
    assign wd_exp    = wd_cnt == WD_W'(TIMEOUT - 1);
    // The compare slot is only meaningful while reading; anything in flight at DONE is dropped.
    assign cmp_en    = vld_pipe[STAGES] && (state == S_READ || state == S_DRAIN);
    assign word_bad  = cmp_en && (B_i_V_q1 != exp_q);
    assign to_read   = (state == S_START && core_ap_ready && core_ap_done) ||
                       (state == S_WAIT && core_ap_done);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (run) state_nxt = S_START;
            S_START: begin
                if (core_ap_ready) state_nxt = core_ap_done ? S_READ : S_WAIT;
            end
            S_WAIT: begin
                if (core_ap_done) state_nxt = S_READ;
                else if (wd_exp)  state_nxt = S_DONE;
            end
            S_READ: begin
                if (last_addr) state_nxt = S_DRAIN;
`ifdef MSM_SEQ_STOP_ON_MISMATCH_EN
                if (word_bad) state_nxt = S_DONE;
`endif
            end
            S_DRAIN: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        core_ap_start = state == S_START;
        B_i_V_ce1     = state == S_READ;
        busy          = !(state == S_IDLE || state == S_DONE);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_addr   <= '0;
            cmp_addr  <= '0;
            vld_pipe  <= '0;
            wd_cnt    <= '0;
            cyc_cnt   <= '0;
            mm_cnt    <= '0;
            bad_addr  <= '0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], state_nxt == S_READ};
            cmp_addr <= rd_addr;
            if (start_acc) begin
                done_r    <= 1'b0;
                timeout_r <= 1'b0;
                mm_cnt    <= '0;
                bad_addr  <= '0;
                cyc_cnt   <= '0;
                wd_cnt    <= '0;
            end
            if (state == S_WAIT) begin
                if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
                wd_cnt <= wd_cnt + 1'b1;
                if (!core_ap_done && wd_exp) timeout_r <= 1'b1;
            end
            // Address only moves inside the read phase, otherwise it holds.
            if (to_read) rd_addr <= '0;
            else if (state == S_READ && !last_addr) rd_addr <= rd_addr + 1'b1;
            if (word_bad) begin
                if (mm_cnt == '0) bad_addr <= cmp_addr;
                if (mm_cnt != (AW+1)'(NUM_BKT)) mm_cnt <= mm_cnt + 1'b1;
            end
            if (state_nxt == S_DONE && state != S_DONE) done_r <= 1'b1;
        end
    end

    assign B_i_V_address1 = rd_addr;
    assign B_i_V_we1      = 1'b0;
    assign B_i_V_d1       = '0;
    assign exp_address    = rd_addr;
    assign exp_ce         = B_i_V_ce1;
    assign done           = done_r;
    assign timeout        = timeout_r;
    assign mismatch_cnt   = mm_cnt;
    assign first_bad_addr = bad_addr;
    assign core_cycles    = cyc_cnt;
    assign pass           = done_r && !timeout_r && (mm_cnt == '0);
    assign debug          = done_r && !pass;

endmodule
